// File: rtl/keychain_host.sv
// keychain_host: packs {modulus, exponent, value} into one UART request frame and waits for the exp-mod result
module keychain_host #(
  parameter int KEY_WIDTH = 32,
  parameter int MSG_WIDTH = 16,
  parameter int BAUD_RATE = 115_200,
  parameter int CLK_FREQ = 100_000_000,
  parameter int TIMEOUT_CYCLES = 10_000_000
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 start_in,
  input  logic [MSG_WIDTH-1:0] value_in,
  input  logic [KEY_WIDTH-1:0] exponent_in,
  input  logic [KEY_WIDTH-1:0] modulus_in,
  output logic                 busy_out,
  output logic                 valid_out,
  output logic                 error_out,
  output logic [KEY_WIDTH-1:0] result_out,
  output logic                 tx_wire_out,
  input  logic                 rx_wire_in
);
  localparam int BAUD_DIV = CLK_FREQ / BAUD_RATE;
  localparam int REQ_WIDTH = MSG_WIDTH + 2 * KEY_WIDTH;
  localparam int BW = $clog2(BAUD_DIV);
  localparam int NW = $clog2(REQ_WIDTH + 2);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);
  localparam logic [BW-1:0] HALF_LAST = BW'(BAUD_DIV / 2 - 1);
  localparam logic [NW-1:0] TX_LAST = NW'(REQ_WIDTH + 1);
  localparam logic [NW-1:0] RX_LAST = NW'(KEY_WIDTH + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {IDLE, TX, WAIT_RX, RX, DONE} state_t;
  state_t state, state_nx;
  logic [BW-1:0] baud_cnt;
  logic [NW-1:0] bit_cnt;
  logic [TW-1:0] tmo_cnt;
  logic [REQ_WIDTH:0] tx_sh;
  logic [KEY_WIDTH-1:0] rx_sh;
  logic rx_m, rx_s, rx_p, ok;
  logic bit_end, rx_sample, fall;

  assign bit_end = baud_cnt == BAUD_LAST;
  // the start bit is sampled half a bit in so every later sample lands mid-bit
  assign rx_sample = bit_cnt == '0 ? baud_cnt == HALF_LAST : bit_end;
  assign fall = rx_p & ~rx_s;
  assign busy_out = state inside {TX, WAIT_RX, RX};
  assign valid_out = state == DONE && ok;
  assign error_out = state == DONE && !ok;

  always_ff @(posedge clk_in or posedge rst_in)
    if (rst_in) state <= IDLE;
    else state <= state_nx;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: state_nx = start_in ? TX : IDLE;
      TX: state_nx = bit_end && bit_cnt == TX_LAST ? WAIT_RX : TX;
      WAIT_RX: state_nx = fall ? RX : tmo_cnt >= TMO_LAST ? DONE : WAIT_RX;
      RX: begin
        if (rx_sample && bit_cnt == '0 && rx_s) state_nx = WAIT_RX;
        else if (rx_sample && bit_cnt == RX_LAST) state_nx = DONE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in)
    if (rst_in) begin
      {rx_m, rx_s, rx_p} <= '1;
      tx_wire_out <= 1'b1;
      tx_sh <= '0;
      rx_sh <= '0;
      baud_cnt <= '0;
      bit_cnt <= '0;
      tmo_cnt <= '0;
      ok <= 1'b0;
      result_out <= '0;
    end else begin
      {rx_p, rx_s, rx_m} <= {rx_s, rx_m, rx_wire_in};
      case (state)
        IDLE: if (start_in) begin
          tx_sh <= {1'b1, modulus_in, exponent_in, value_in};
          tx_wire_out <= 1'b0;
          baud_cnt <= '0;
          bit_cnt <= '0;
        end
        TX: begin
          baud_cnt <= bit_end ? '0 : baud_cnt + 1'b1;
          tmo_cnt <= '0;
          if (bit_end) begin
            tx_wire_out <= tx_sh[0];
            tx_sh <= {1'b1, tx_sh[REQ_WIDTH:1]};
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        WAIT_RX: begin
          tmo_cnt <= tmo_cnt == TMO_MAX ? tmo_cnt : tmo_cnt + 1'b1;
          baud_cnt <= '0;
          bit_cnt <= '0;
          ok <= 1'b0;
        end
        RX: begin
          // a rejected glitch must not buy the responder extra time
          tmo_cnt <= tmo_cnt == TMO_MAX ? tmo_cnt : tmo_cnt + 1'b1;
          baud_cnt <= rx_sample ? '0 : baud_cnt + 1'b1;
          if (rx_sample) begin
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == RX_LAST) begin
              ok <= rx_s;
              if (rx_s) result_out <= rx_sh;
            end else if (bit_cnt != '0) rx_sh <= {rx_s, rx_sh[KEY_WIDTH-1:1]};
          end
        end
        default: ;
      endcase
    end
endmodule

// File: tb/tb_keychain_host.sv
// tb_keychain_host: randomized request/response scenarios checked against a transaction-level model
module tb_keychain_host;
  localparam int KW = 32, MW = 16, RW = MW + 2 * KW, BD = 16, TMO = 1000;
  localparam int FRAME = (RW + 2) * BD;

  logic clk_in = 1'b0, rst_in = 1'b1, start_in = 1'b0, rx_wire_in = 1'b1;
  logic [MW-1:0] value_in = '0;
  logic [KW-1:0] exponent_in = '0, modulus_in = '0;
  logic busy_out, valid_out, error_out, tx_wire_out;
  logic [KW-1:0] result_out;

  int n_cmp = 0, n_bad = 0, cyc = 0;
  int n_valid = 0, n_error = 0, n_both = 0, n_long = 0;
  int busy_bad = 0, res_bad = 0, tx_bad = 0, pulse_cyc = 0;
  bit tx_idle_chk = 1'b0;
  logic prev_v = 1'b0, prev_e = 1'b0, prev_busy = 1'b0;
  logic [KW-1:0] prev_res = '0, exp_res = '0;

  keychain_host #(
    .KEY_WIDTH(KW), .MSG_WIDTH(MW), .BAUD_RATE(115_200),
    .CLK_FREQ(1_843_200), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk_in(clk_in), .rst_in(rst_in), .start_in(start_in),
    .value_in(value_in), .exponent_in(exponent_in), .modulus_in(modulus_in),
    .busy_out(busy_out), .valid_out(valid_out), .error_out(error_out),
    .result_out(result_out), .tx_wire_out(tx_wire_out), .rx_wire_in(rx_wire_in)
  );

  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) cyc <= cyc + 1;

  // protocol watcher: pulse shape, busy alignment, result stability, quiet tx line
  always @(negedge clk_in) begin
    if (!rst_in) begin
      if (valid_out && error_out) n_both++;
      if ((valid_out && prev_v) || (error_out && prev_e)) n_long++;
      if (valid_out) n_valid++;
      if (error_out) n_error++;
      if ((valid_out || error_out) && (busy_out || !prev_busy)) busy_bad++;
      if (valid_out || error_out) pulse_cyc = cyc;
      if (result_out !== prev_res && !valid_out) res_bad++;
      if (tx_idle_chk && !tx_wire_out) tx_bad++;
    end
    prev_v = valid_out;
    prev_e = error_out;
    prev_busy = busy_out;
    prev_res = result_out;
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk_in);
  endtask

  task automatic drive_rsp(input logic [KW-1:0] d, input logic stop, output int stop_cyc);
    logic [KW+1:0] fr;
    fr = {stop, d, 1'b0};
    stop_cyc = 0;
    for (int b = 0; b < KW + 2; b++) begin
      rx_wire_in = fr[b];
      if (b == KW + 1) stop_cyc = cyc;
      tick(BD);
    end
    rx_wire_in = 1'b1;
  endtask

  task automatic capture(input logic [RW-1:0] req, input bit poke, output int f);
    logic [RW+1:0] fr, dec;
    int werr = 0, berr = 0, w = 0;
    fr = {1'b1, req, 1'b0};
    dec = '0;
    while (tx_wire_out && w < 4) begin
      tick(1);
      w++;
    end
    check("tx_start_seen", tx_wire_out, 0);
    f = cyc;
    for (int i = 0; i < FRAME; i++) begin
      if (i > 0) tick(1);
      if (tx_wire_out !== fr[i/BD]) werr++;
      if (busy_out !== 1'b1) berr++;
      if (i % BD == BD / 2) dec[i/BD] = tx_wire_out;
      if (poke && (i == 100 || i == 103)) begin
        start_in = i == 100;
        value_in = ~value_in;
      end
    end
    check("tx_wave", werr, 0);
    check("tx_busy", berr, 0);
    check("tx_data", dec[RW:1], req);
    check("tx_framing", {dec[RW+1], dec[0]}, 2'b10);
  endtask

  // kind: 0 good response, 1 no response, 2 glitch then good, 3 bad stop bit
  task automatic run_txn(input int kind, input logic [MW-1:0] v, input logic [KW-1:0] e,
                         input logic [KW-1:0] m, input logic [KW-1:0] rsp,
                         input bit poke, input bit b2b);
    int f, p, nv, ne, w;
    value_in = v;
    exponent_in = e;
    modulus_in = m;
    if (b2b) begin
      start_in = 1'b1;
      tick(1);
      check("done_start_ignored", {busy_out, tx_wire_out}, 2'b01);
      tick(1);
      start_in = 1'b0;
    end else begin
      tick(2);
      check("idle_before_start", busy_out, 0);
      start_in = 1'b1;
      tick(1);
      start_in = 1'b0;
    end
    check("accept_busy", busy_out, 1);
    capture({m, e, v}, poke, f);
    tx_idle_chk = 1'b1;
    nv = n_valid;
    ne = n_error;
    if (kind == 1) begin
      w = 0;
      while (!error_out && !valid_out && w < TMO + 50) begin
        tick(1);
        w++;
      end
      check("timeout_cycle", cyc - f, FRAME + TMO);
      #1;
    end else begin
      tick($urandom_range(2, 30));
      if (kind == 2) begin
        rx_wire_in = 1'b0;
        tick(4);
        rx_wire_in = 1'b1;
        tick(40);
        check("glitch_no_pulse", (n_valid - nv) + (n_error - ne), 0);
        check("glitch_busy", busy_out, 1);
      end
      drive_rsp(rsp, kind != 3, p);
      tick(3);
      check("rsp_timing", pulse_cyc > p && pulse_cyc < p + BD, 1);
      if (kind != 3) exp_res = rsp;
    end
    check("valid_pulses", n_valid - nv, (kind == 0 || kind == 2) ? 1 : 0);
    check("error_pulses", n_error - ne, (kind == 1 || kind == 3) ? 1 : 0);
    check("result", result_out, exp_res);
    check("busy_after", busy_out, 0);
    tx_idle_chk = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: run did not end, got cycle %0d expected completion", cyc);
    $fatal(1);
  end

  initial begin
    int nv, ne, kind, last_kind;
    tick(3);
    check("rst_tx", tx_wire_out, 1);
    check("rst_busy", busy_out, 0);
    check("rst_valid", valid_out, 0);
    check("rst_error", error_out, 0);
    check("rst_result", result_out, 0);
    rst_in = 1'b0;
    tick(2);

    run_txn(0, 16'h0041, 32'h0001_0001, 32'hC0A8_0101, 32'h1234_5678, 0, 0);
    run_txn(1, 16'($urandom), $urandom, $urandom, 32'h0, 0, 0);
    run_txn(2, 16'($urandom), $urandom, $urandom, 32'hDEAD_BEEF, 1, 1);
    run_txn(3, 16'($urandom), $urandom, $urandom, 32'hA5A5_A5A5, 0, 0);

    value_in = 16'($urandom);
    exponent_in = $urandom;
    modulus_in = $urandom;
    tick(2);
    start_in = 1'b1;
    tick(1);
    start_in = 1'b0;
    nv = n_valid;
    ne = n_error;
    tick(20 * BD + 5);
    rst_in = 1'b1;
    #1;
    check("midtx_rst_tx", tx_wire_out, 1);
    check("midtx_rst_busy", busy_out, 0);
    tick(2);
    rst_in = 1'b0;
    exp_res = '0;
    tick(3);
    check("midtx_no_pulse", (n_valid - nv) + (n_error - ne), 0);
    check("midtx_result", result_out, 0);
    run_txn(0, 16'($urandom), $urandom, $urandom, $urandom, 0, 0);

    last_kind = 0;
    for (int t = 0; t < 8; t++) begin
      kind = $urandom_range(0, 3);
      run_txn(kind, 16'($urandom), $urandom, $urandom, $urandom,
              bit'($urandom_range(0, 1)), last_kind == 1 && $urandom_range(0, 1) == 1);
      last_kind = kind;
    end

    tick(5);
    check("never_both", n_both, 0);
    check("single_cycle_pulses", n_long, 0);
    check("busy_falls_with_pulse", busy_bad, 0);
    check("result_only_on_valid", res_bad, 0);
    check("tx_quiet_after_frame", tx_bad, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
